// File: rtl/link_scheduler.sv
// Arbitrates the shared 3-bit data + control output link between the keypress echo sender
// and the secret-code transmitter, buffering keypresses in a small FIFO while the link is busy.
module link_scheduler #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned GAP_CYCLES = 1200,
   parameter int unsigned MAX_HOLD   = 24000000
) (
   input  logic                        hwclk,
   input  logic                        reset,
   input  logic                        key_valid,
   input  logic [3:0]                  key_digit,
   input  logic                        secret_req,
   input  logic                        secret_done,
   input  logic                        send_active,
   input  logic [3:0]                  send_out,
   input  logic [3:0]                  secret_out,
   output logic [3:0]                  send_num,
   output logic                        send_enable,
   output logic                        secret_enable,
   output logic [2:0]                  link_out,
   output logic                        link_ctrl,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   output logic                        timeout
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned WW = $clog2(MAX_HOLD + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {StIdle, StKeyLoad, StKeySend, StSecret, StGap} state_e;

   state_e          state;
   logic            last_secret;
   logic            seen_active;
   logic [WW-1:0]   wd_cnt;
   logic [GW-1:0]   gap_cnt;

   logic [3:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            pop;
   logic            full;
   logic            empty;
   logic            push_ok;

   assign pop     = (state == StKeyLoad);
   assign full    = (fifo_count == (PW + 1)'(FIFO_DEPTH));
   assign empty   = (fifo_count == '0);
   assign push_ok = key_valid && (!full || pop);
   assign busy    = (state != StIdle);

   // Digit storage carries no reset; only pointers and count define validity.
   always_ff @(posedge hwclk) begin
      if (push_ok) begin
         mem[wr_ptr] <= key_digit;
      end
   end

   always_ff @(posedge hwclk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         overflow <= key_valid && full && !pop;
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Link mux follows the next owner so the pins read zero for the whole gap.
   always_ff @(posedge hwclk or posedge reset) begin
      if (reset) begin
         state         <= StIdle;
         last_secret   <= 1'b0;
         seen_active   <= 1'b0;
         wd_cnt        <= '0;
         gap_cnt       <= '0;
         send_num      <= '0;
         send_enable   <= 1'b0;
         secret_enable <= 1'b0;
         link_out      <= '0;
         link_ctrl     <= 1'b0;
         timeout       <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            StIdle: begin
               if (secret_req && (!last_secret || empty)) begin
                  state                 <= StSecret;
                  last_secret           <= 1'b1;
                  secret_enable         <= 1'b1;
                  wd_cnt                <= '0;
                  {link_ctrl, link_out} <= secret_out;
               end else if (!empty) begin
                  state                 <= StKeyLoad;
                  last_secret           <= 1'b0;
                  send_num              <= mem[rd_ptr];
                  send_enable           <= 1'b1;
                  wd_cnt                <= '0;
                  {link_ctrl, link_out} <= send_out;
               end else begin
                  {link_ctrl, link_out} <= 4'b0000;
               end
            end
            StKeyLoad: begin
               state                 <= StKeySend;
               seen_active           <= 1'b0;
               send_enable           <= 1'b1;
               {link_ctrl, link_out} <= send_out;
            end
            StKeySend: begin
               if ((seen_active && !send_active) || (wd_cnt == WW'(MAX_HOLD - 1))) begin
                  timeout               <= !(seen_active && !send_active);
                  state                 <= StGap;
                  gap_cnt               <= '0;
                  send_enable           <= 1'b0;
                  {link_ctrl, link_out} <= 4'b0000;
               end else begin
                  wd_cnt                <= wd_cnt + 1'b1;
                  send_enable           <= send_active;
                  seen_active           <= seen_active | send_active;
                  {link_ctrl, link_out} <= send_out;
               end
            end
            StSecret: begin
               // A dropped request aborts the transfer just like completion does.
               if (secret_done || !secret_req || (wd_cnt == WW'(MAX_HOLD - 1))) begin
                  timeout               <= !(secret_done || !secret_req);
                  state                 <= StGap;
                  gap_cnt               <= '0;
                  secret_enable         <= 1'b0;
                  {link_ctrl, link_out} <= 4'b0000;
               end else begin
                  wd_cnt                <= wd_cnt + 1'b1;
                  {link_ctrl, link_out} <= secret_out;
               end
            end
            StGap: begin
               {link_ctrl, link_out} <= 4'b0000;
               if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                  state <= StIdle;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_link_scheduler.sv
// Self-checking bench for link_scheduler: vector table for single keypresses, scoreboard of
// expected digits popped on each key grant, and hand sequences for multi-cycle corners.
module tb_link_scheduler;

   localparam int unsigned FD  = 4;
   localparam int unsigned GAP = 8;
   localparam int unsigned MH  = 1000;

   logic       hwclk = 1'b0;
   logic       reset = 1'b1;
   logic       key_valid = 1'b0;
   logic [3:0] key_digit = '0;
   logic       secret_req = 1'b0;
   logic       secret_done = 1'b0;
   logic       send_active;
   logic [3:0] send_out = '0;
   logic [3:0] secret_out = '0;
   logic [3:0] send_num;
   logic       send_enable;
   logic       secret_enable;
   logic [2:0] link_out;
   logic       link_ctrl;
   logic       busy;
   logic [2:0] fifo_count;
   logic       overflow;
   logic       timeout;

   link_scheduler #(
      .FIFO_DEPTH(FD),
      .GAP_CYCLES(GAP),
      .MAX_HOLD  (MH)
   ) dut (
      .hwclk        (hwclk),
      .reset        (reset),
      .key_valid    (key_valid),
      .key_digit    (key_digit),
      .secret_req   (secret_req),
      .secret_done  (secret_done),
      .send_active  (send_active),
      .send_out     (send_out),
      .secret_out   (secret_out),
      .send_num     (send_num),
      .send_enable  (send_enable),
      .secret_enable(secret_enable),
      .link_out     (link_out),
      .link_ctrl    (link_ctrl),
      .busy         (busy),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .timeout      (timeout)
   );

   always #5 hwclk = ~hwclk;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [3:0]  exp_q [$];
   logic [31:0] grant_log = '0;
   int          ov_seen = 0;
   logic        se_prev = 1'b0;
   logic        sc_prev = 1'b0;
   logic        stuck = 1'b0;

   typedef struct {
      logic [3:0] digit;
      logic [3:0] pat;
      logic [3:0] exp_num;
      logic [3:0] exp_link;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge hwclk);
         #1;
      end
   endtask

   task automatic wait_idle(input int budget);
      int i;
      i = 0;
      while (busy && i < budget) begin
         tick(1);
         i++;
      end
      chk("wait_idle", {31'b0, busy}, 0);
   endtask

   task automatic measure_gap(output int g, output logic lz);
      g  = 0;
      lz = 1'b1;
      while (busy && g < 5000) begin
         if ({link_ctrl, link_out} != 4'b0) lz = 1'b0;
         g++;
         tick(1);
      end
   endtask

   // Sender model: answers a fresh enable with a 4-cycle active burst, or sticks high.
   initial begin : sender_model
      int  cnt;
      logic armed;
      cnt = 0;
      armed = 1'b1;
      send_active = 1'b0;
      forever begin
         @(posedge hwclk);
         #2;
         if (stuck) send_active = 1'b1;
         else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) send_active = 1'b0;
         end else if (send_enable && armed) begin
            send_active = 1'b1;
            cnt = 4;
            armed = 1'b0;
         end else send_active = 1'b0;
         if (!send_enable) armed = 1'b1;
      end
   end

   always @(negedge hwclk) begin : monitor
      logic [3:0] e;
      if (send_enable && !se_prev) begin
         grant_log = {grant_log[29:0], 2'b10};
         chk("sb_has_expect", {31'b0, exp_q.size() > 0}, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_send_num", {28'b0, send_num}, {28'b0, e});
         end
      end
      if (secret_enable && !sc_prev) grant_log = {grant_log[29:0], 2'b01};
      if (overflow) ov_seen++;
      se_prev = send_enable;
      sc_prev = secret_enable;
   end

   initial begin
      #600000;
      $display("FAIL global_timeout: got running, want finished");
      $fatal(1, "bench time limit");
   end

   initial begin : main
      vec_t       vecs [4];
      logic [3:0] dg [5];
      logic [3:0] nl;
      int         g;
      int         i;
      int         k;
      int         ov0;
      logic       lz;
      logic       held;

      vecs[0] = '{4'd5, 4'hA, 4'd5, 4'hA};
      vecs[1] = '{4'd0, 4'h1, 4'd0, 4'h1};
      vecs[2] = '{4'hF, 4'hF, 4'hF, 4'hF};
      vecs[3] = '{4'h8, 4'h6, 4'h8, 4'h6};
      dg = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7};

      tick(2);
      chk("reset_outputs", {16'b0, send_num, send_enable, secret_enable, link_ctrl, link_out,
                            busy, fifo_count, overflow, timeout}, 0);
      reset = 1'b0;
      tick(1);
      chk("post_reset_idle", {16'b0, send_num, send_enable, secret_enable, link_ctrl, link_out,
                              busy, fifo_count, overflow, timeout}, 0);

      // Single keypresses from idle
      foreach (vecs[v]) begin
         key_valid = 1'b1;
         key_digit = vecs[v].digit;
         send_out  = vecs[v].pat;
         exp_q.push_back(vecs[v].exp_num);
         tick(1);
         key_valid = 1'b0;
         chk("key_pushed", {29'b0, fifo_count}, 1);
         chk("key_no_early_en", {31'b0, send_enable}, 0);
         tick(1);
         chk("key_en_2cyc", {31'b0, send_enable}, 1);
         chk("key_send_num", {28'b0, send_num}, {28'b0, vecs[v].exp_num});
         chk("key_link_first", {28'b0, link_ctrl, link_out}, {28'b0, vecs[v].exp_link});
         nl = ~vecs[v].exp_link;
         send_out = nl;
         tick(1);
         chk("key_popped", {29'b0, fifo_count}, 0);
         chk("key_link_follow", {28'b0, link_ctrl, link_out}, {28'b0, nl});
         i = 0;
         while (send_enable && i < 50) begin
            tick(1);
            i++;
         end
         chk("key_en_dropped", {31'b0, send_enable}, 0);
         measure_gap(g, lz);
         chk("key_gap_len", g, GAP);
         chk("key_gap_link0", {31'b0, lz}, 1);
         chk("key_gap_end_idle", {31'b0, busy}, 0);
      end

      // Secret transfer of 500 cycles
      secret_out = 4'h6;
      secret_req = 1'b1;
      chk("secret_pre", {31'b0, secret_enable}, 0);
      tick(1);
      chk("secret_grant", {31'b0, secret_enable}, 1);
      chk("secret_link0", {28'b0, link_ctrl, link_out}, 32'h6);
      secret_out = 4'hC;
      tick(1);
      chk("secret_link_follow", {28'b0, link_ctrl, link_out}, 32'hC);
      held = 1'b1;
      for (int c = 0; c < 498; c++) begin
         if (!secret_enable) held = 1'b0;
         tick(1);
      end
      chk("secret_held", {31'b0, held & secret_enable}, 1);
      secret_done = 1'b1;
      tick(1);
      secret_done = 1'b0;
      secret_req  = 1'b0;
      chk("secret_end_en", {31'b0, secret_enable}, 0);
      chk("secret_end_busy", {31'b0, busy}, 1);
      measure_gap(g, lz);
      chk("secret_gap_len", g, GAP);
      chk("secret_gap_link0", {31'b0, lz}, 1);

      // Abort: request drops before done
      secret_req = 1'b1;
      tick(4);
      secret_req = 1'b0;
      tick(1);
      chk("abort_en", {31'b0, secret_enable}, 0);
      chk("abort_gap", {31'b0, busy}, 1);
      wait_idle(100);

      // Keys arriving during SECRET, fifth one overflows
      secret_req = 1'b1;
      tick(1);
      ov0 = ov_seen;
      for (int d = 0; d < 5; d++) begin
         key_valid = 1'b1;
         key_digit = dg[d];
         if (d < 4) exp_q.push_back(dg[d]);
         tick(1);
         key_valid = 1'b0;
         chk("ovf_flag", {31'b0, overflow}, (d == 4) ? 1 : 0);
      end
      chk("ovf_count_full", {29'b0, fifo_count}, 4);
      tick(1);
      chk("ovf_one_cycle", {31'b0, overflow}, 0);
      chk("ovf_pulses", ov_seen - ov0, 1);
      chk("ovf_secret_kept", {31'b0, secret_enable}, 1);
      secret_done = 1'b1;
      secret_req  = 1'b0;
      tick(1);
      secret_done = 1'b0;
      i = 0;
      while ((busy || fifo_count != 0) && i < 500) begin
         tick(1);
         i++;
      end
      chk("ovf_drained", {29'b0, fifo_count}, 0);
      chk("ovf_sb_empty", exp_q.size(), 0);

      // Watchdog on stuck send_active
      wait_idle(100);
      stuck = 1'b1;
      key_valid = 1'b1;
      key_digit = 4'd3;
      exp_q.push_back(4'd3);
      tick(1);
      key_valid = 1'b0;
      tick(2);
      k = 0;
      while (!timeout && k < int'(MH) + 50) begin
         tick(1);
         k++;
      end
      chk("wd_cycles", k, MH);
      chk("wd_en_drop", {31'b0, send_enable}, 0);
      chk("wd_gap", {31'b0, busy}, 1);
      stuck = 1'b0;
      tick(1);
      chk("wd_one_cycle", {31'b0, timeout}, 0);
      wait_idle(100);

      // Reset in the middle of SECRET with two digits queued
      secret_req = 1'b1;
      tick(1);
      key_valid = 1'b1;
      key_digit = 4'd8;
      tick(1);
      key_digit = 4'd9;
      tick(1);
      key_valid = 1'b0;
      chk("rst_queued", {29'b0, fifo_count}, 2);
      tick(5);
      reset = 1'b1;
      #1;
      chk("rst_async_outputs", {16'b0, send_num, send_enable, secret_enable, link_ctrl,
                                link_out, busy, fifo_count, overflow, timeout}, 0);
      tick(1);
      reset = 1'b0;
      secret_req = 1'b0;
      tick(1);
      chk("rst_after_state", {28'b0, busy, fifo_count}, 0);
      tick(GAP + 3);
      chk("rst_stays_idle", {31'b0, busy}, 0);

      // Contention from reset: secret, key, secret, key
      reset = 1'b1;
      tick(1);
      grant_log = '0;
      reset = 1'b0;
      secret_req = 1'b1;
      key_valid = 1'b1;
      key_digit = 4'd9;
      exp_q.push_back(4'd9);
      tick(1);
      key_digit = 4'hC;
      exp_q.push_back(4'hC);
      tick(1);
      key_valid = 1'b0;
      chk("alt_fifo", {29'b0, fifo_count}, 2);
      chk("alt_secret_first", {31'b0, secret_enable}, 1);
      tick(20);
      secret_done = 1'b1;
      tick(1);
      secret_done = 1'b0;
      i = 0;
      while (!send_enable && i < 100) begin
         tick(1);
         i++;
      end
      chk("alt_key_grant", {31'b0, send_enable}, 1);
      i = 0;
      while (!secret_enable && i < 200) begin
         tick(1);
         i++;
      end
      chk("alt_secret_again", {31'b0, secret_enable}, 1);
      chk("alt_key_waiting", {29'b0, fifo_count}, 1);
      tick(10);
      secret_done = 1'b1;
      secret_req  = 1'b0;
      tick(1);
      secret_done = 1'b0;
      i = 0;
      while ((busy || fifo_count != 0) && i < 300) begin
         tick(1);
         i++;
      end
      chk("alt_grant_order", grant_log, 32'h66);
      chk("sb_final_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/link_scheduler.md
# link_scheduler

Schedules the shared 3-bit data plus control output link (LED and Arduino pins) between the keypress-echo `sender` and the secret-code `multisend` transmitter. It sits between `enterDigit`/`controller` and the two transmitters. Keypress digits that arrive while the link is busy are buffered in a small FIFO rather than lost. Link ownership is granted one transfer at a time, with an idle guard gap between owners and a watchdog on each transfer.

## Interface
- FIFO_DEPTH, 4, keypress digit buffer depth (power of two, 2..16)
- GAP_CYCLES, 1200, idle cycles forced on the link between transfers (100 µs at 12 MHz)
- MAX_HOLD, 24000000, watchdog limit in cycles for any single transfer (2 s)
- hwclk  in  1  system clock, 12 MHz
- reset  in  1  asynchronous, active-high; clears all state
- key_valid  in  1  one-cycle pulse: new keypress (rising edge of bstate)
- key_digit  in  4  keypress code, sampled when key_valid=1
- secret_req  in  1  level: secret transmission requested (sendSecret & !locked)
- secret_done  in  1  from multisend: transfer complete
- send_active  in  1  from sender: nibble transfer in progress
- send_out  in  4  from sender: {controlOut, out2, out1, out0}
- secret_out  in  4  from multisend: {controlOut, out2, out1, out0}
- send_num  out  4  digit presented to sender
- send_enable  out  1  enable to sender
- secret_enable  out  1  enable to multisend
- link_out  out  3  shared data pins {2,1,0}
- link_ctrl  out  1  shared control pin
- busy  out  1  state ≠ IDLE
- fifo_count  out  log2(FIFO_DEPTH)+1  buffered digits
- overflow  out  1  one-cycle pulse: keypress dropped, FIFO full
- timeout  out  1  one-cycle pulse: watchdog forced release

## Operation
- States: IDLE, KEY_LOAD, KEY_SEND, SECRET, GAP.
- IDLE: if secret_req=1 and (last_owner=KEY or FIFO empty), go to SECRET. Otherwise, if the FIFO is non-empty, go to KEY_LOAD. Otherwise stay in IDLE.
- last_owner is set at each grant and resets to KEY, so the secret wins the first contention. Under contention the two owners alternate, which prevents starvation.
- KEY_LOAD (one cycle): send_num ← FIFO head; pop; send_enable=1; next state KEY_SEND.
- KEY_SEND: send_enable=send_active. The state sets seen_active when send_active=1. Exit to GAP when seen_active=1 and send_active=0.
- SECRET: secret_enable=1 and stays 1 while in this state. Exit to GAP on secret_done=1.
  - If secret_req drops before secret_done, exit to GAP on the next cycle (abort).
- GAP: link forced idle for GAP_CYCLES cycles, then go to IDLE.
- Link mux:
  - KEY_LOAD/KEY_SEND: {link_ctrl, link_out} = send_out
  - SECRET: {link_ctrl, link_out} = secret_out
  - IDLE/GAP: 4'b0000
  - The mux is registered, so outputs lag their source by one cycle.
- Watchdog: a 25-bit counter clears on entry to KEY_LOAD or SECRET and increments while in KEY_SEND or SECRET. Reaching MAX_HOLD causes a timeout pulse, deasserts both enables, and moves to GAP.
- FIFO: push on key_valid.
  - Full with no pop in the same cycle: drop the digit, pulse overflow, leave contents unchanged.
  - Full with a simultaneous pop (KEY_LOAD): the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-transfer: all outputs go to 0 immediately, the FIFO empties, state becomes IDLE, and last_owner becomes KEY. The transmitters see their enable drop and must self-abort.

## Timing
- Reset values: send_num=0, send_enable=0, secret_enable=0, link_out=0, link_ctrl=0, busy=0, fifo_count=0, overflow=0, timeout=0.
- key_valid in an idle system:
  - push at edge N; IDLE→KEY_LOAD at N+1; send_enable=1 during cycle N+1 to N+2.
  - Latency from key_valid to send_enable is 2 cycles.
- secret_req in IDLE: secret_enable is asserted 1 cycle after the edge that samples it.
- Minimum spacing between successive grants is GAP_CYCLES+1 cycles. The link reads 0 throughout the gap.
- fifo_count updates on the same edge as the push or pop. overflow and timeout are each high for exactly one cycle.

## Test plan
- Reset, then key_valid with key_digit=5 → send_num=5 and send_enable=1 two cycles later. link follows send_out delayed one cycle. After send_active falls, link=0 for 1200 cycles and busy drops.
- Hold secret_req=1; secret_done after 500 cycles → secret_enable high for 500 cycles, then GAP, then IDLE. link mirrors secret_out during the transfer.
- During SECRET, pulse key_valid with 1, 2, 3, 4, 7 → fifo_count reaches 4 and overflow pulses once (digit 7 dropped). After the gap, digits 1, 2, 3, 4 are sent in order.
- secret_req and a non-empty FIFO present together from reset → SECRET is granted first, then one key, then SECRET again if still requested (alternation).
- send_active stuck at 1 → timeout pulses after exactly 24000000 cycles in KEY_SEND, send_enable drops, and the block enters GAP.
- Assert reset mid-SECRET with 2 digits queued → all outputs are 0 asynchronously. After release, fifo_count=0 and state is IDLE.
